// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: launches multiply requests into the M-extension multiplier, stalls until ready, caches the last result
module mul_issue_ctrl #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_rdata1,
  input  logic [31:0] ex_rdata2,
  input  logic [4:0]  ex_waddr,
  input  logic        flush,
  output logic        stall,
  output logic        mul_enable,
  output logic [3:0]  mul_op,
  output logic [31:0] mul_rdata1,
  output logic [31:0] mul_rdata2,
  input  logic [31:0] mul_result,
  input  logic        mul_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_result
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t      state;
  logic [3:0]  held_op, cache_op;
  logic [31:0] held_r1, held_r2, cache_r1, cache_r2, cache_result;
  logic [4:0]  held_waddr;
  logic        cache_valid, idle, legal, hit, launch;
  // request qualification, cache lookup, and multiplier/stall drive (operands come straight from ex only while idle)
  always_comb begin
    idle       = state == IDLE;
    legal      = ex_valid && $onehot(ex_op) && !flush;
    hit        = CACHE_EN && cache_valid && ex_op == cache_op && ex_rdata1 == cache_r1 && ex_rdata2 == cache_r2;
    launch     = idle && legal && !hit;
    mul_enable = launch;
    mul_op     = idle ? ex_op : held_op;
    mul_rdata1 = idle ? ex_rdata1 : held_r1;
    mul_rdata2 = idle ? ex_rdata2 : held_r2;
    stall      = launch ? !mul_ready : state == BUSY ? !mul_ready : state == DRAIN;
  end
  // sequencer: launch, wait for the multiplier, write back, or drain a flushed operation that cannot be aborted
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      wb_valid     <= 1'b0;
      wb_waddr     <= '0;
      wb_result    <= '0;
      held_op      <= '0;
      held_r1      <= '0;
      held_r2      <= '0;
      held_waddr   <= '0;
      cache_valid  <= 1'b0;
      cache_op     <= '0;
      cache_r1     <= '0;
      cache_r2     <= '0;
      cache_result <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (legal && hit) begin
            wb_valid  <= 1'b1;
            wb_result <= cache_result;
            wb_waddr  <= ex_waddr;
          end else if (launch) begin
            held_op    <= ex_op;
            held_r1    <= ex_rdata1;
            held_r2    <= ex_rdata2;
            held_waddr <= ex_waddr;
            if (mul_ready) begin
              wb_valid     <= 1'b1;
              wb_result    <= mul_result;
              wb_waddr     <= ex_waddr;
              cache_valid  <= 1'b1;
              cache_op     <= ex_op;
              cache_r1     <= ex_rdata1;
              cache_r2     <= ex_rdata2;
              cache_result <= mul_result;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mul_ready && !flush) begin
            wb_valid     <= 1'b1;
            wb_result    <= mul_result;
            wb_waddr     <= held_waddr;
            cache_valid  <= 1'b1;
            cache_op     <= held_op;
            cache_r1     <= held_r1;
            cache_r2     <= held_r2;
            cache_result <= mul_result;
            state        <= IDLE;
          end else if (mul_ready) begin
            state <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: if (mul_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed checks of mul_issue_ctrl with cached and uncached instances
module tb_mul_issue_ctrl;
  localparam logic [3:0] MULS = 4'b0001, MULH = 4'b0010, MULHSU = 4'b0100, MULHU = 4'b1000;
  logic        clock, reset, ex_valid, flush, mul_ready;
  logic [3:0]  ex_op;
  logic [31:0] ex_rdata1, ex_rdata2, mul_result;
  logic [4:0]  ex_waddr;
  logic        stall, mul_enable, wb_valid, stall0, mul_enable0, wb_valid0;
  logic [3:0]  mul_op, mul_op0;
  logic [31:0] mul_rdata1, mul_rdata2, wb_result, mul_rdata10, mul_rdata20, wb_result0;
  logic [4:0]  wb_waddr, wb_waddr0;
  int          n_chk = 0, n_pass = 0, en_cnt = 0, en_base;

  mul_issue_ctrl #(.CACHE_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_waddr(ex_waddr), .flush(flush), .stall(stall), .mul_enable(mul_enable),
    .mul_op(mul_op), .mul_rdata1(mul_rdata1), .mul_rdata2(mul_rdata2), .mul_result(mul_result),
    .mul_ready(mul_ready), .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_result(wb_result)
  );

  mul_issue_ctrl #(.CACHE_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_waddr(ex_waddr), .flush(flush), .stall(stall0), .mul_enable(mul_enable0),
    .mul_op(mul_op0), .mul_rdata1(mul_rdata10), .mul_rdata2(mul_rdata20), .mul_result(mul_result),
    .mul_ready(mul_ready), .wb_valid(wb_valid0), .wb_waddr(wb_waddr0), .wb_result(wb_result0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) if (mul_enable) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    ex_valid  = 1'b1;
    ex_op     = op;
    ex_rdata1 = a;
    ex_rdata2 = b;
    ex_waddr  = wa;
  endtask

  // lat=0 means ready in the launch cycle; otherwise ready arrives lat cycles after launch
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic [31:0] mres, input logic [31:0] exp,
                        input int lat, input logic hit);
    @(negedge clock);
    req(op, a, b, wa);
    mul_result = mres;
    mul_ready  = (lat == 0);
    #1;
    chk({tag, "_en"}, 32'(mul_enable), 32'(!hit));
    chk({tag, "_stall0"}, 32'(stall), 32'(lat != 0));
    for (int i = 1; i <= lat; i++) begin
      @(negedge clock);
      mul_ready = (i == lat);
      #1;
      chk({tag, "_stall"}, 32'(stall), 32'(i != lat));
      chk({tag, "_en_busy"}, 32'(mul_enable), 0);
      chk({tag, "_op_held"}, 32'(mul_op), 32'(op));
    end
    @(negedge clock);
    ex_valid  = 1'b0;
    mul_ready = 1'b0;
    #1;
    chk({tag, "_wbv"}, 32'(wb_valid), 1);
    chk({tag, "_wbr"}, wb_result, exp);
    chk({tag, "_wba"}, 32'(wb_waddr), 32'(wa));
  endtask

  initial begin
    reset = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_rdata1 = '0; ex_rdata2 = '0; ex_waddr = '0;
    flush = 1'b0; mul_ready = 1'b0; mul_result = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_wbv", 32'(wb_valid), 0);
    chk("rst_wbr", wb_result, 0);
    chk("rst_wba", 32'(wb_waddr), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_en", 32'(mul_enable), 0);
    @(negedge clock);
    reset = 1'b1;

    run_op("mul", MULS, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 32'hFFFFFFEB, 0, 1'b0);
    @(negedge clock);
    #1;
    chk("pulse_wbv", 32'(wb_valid), 0);
    chk("pulse_hold", wb_result, 32'hFFFFFFEB);

    run_op("mulh_it", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h0, 32'h0, 3, 1'b0);
    run_op("mulhsu_c", MULHSU, 32'hFFFFFFFF, 32'd2, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    run_op("mulh_c", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'h0, 32'h0, 0, 1'b0);
    run_op("mulhsu_it", MULHSU, 32'hFFFFFFFF, 32'd2, 5'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 1'b0);
    en_base = en_cnt;
    run_op("mulhu_it", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, 32'hFFFFFFFE, 5, 1'b0);
    chk("mulhu_one_pulse", 32'(en_cnt - en_base), 1);

    // identical repeat: cached instance bypasses, uncached one relaunches and takes the bogus result
    @(negedge clock);
    req(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12);
    mul_ready = 1'b1; mul_result = 32'hDEADBEEF;
    #1;
    chk("hit_en", 32'(mul_enable), 0);
    chk("hit_stall", 32'(stall), 0);
    chk("nocache_en", 32'(mul_enable0), 1);
    @(negedge clock);
    ex_valid = 1'b0; mul_ready = 1'b0;
    #1;
    chk("hit_wbv", 32'(wb_valid), 1);
    chk("hit_wbr", wb_result, 32'hFFFFFFFE);
    chk("hit_wba", 32'(wb_waddr), 12);
    chk("nocache_wbv", 32'(wb_valid0), 1);
    chk("nocache_wbr", wb_result0, 32'hDEADBEEF);

    // flush three cycles after launch, then a new request waits out the drain
    @(negedge clock);
    req(MULS, 32'd3, 32'd4, 5'd11);
    #1;
    chk("fl_launch", 32'(mul_enable), 1);
    repeat (2) @(negedge clock);
    @(negedge clock);
    flush = 1'b1; ex_valid = 1'b0;
    #1;
    chk("fl_busy_stall", 32'(stall), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      flush = 1'b0;
      req(MULS, 32'd5, 32'd6, 5'd7);
      #1;
      chk("drain_stall", 32'(stall), 1);
      chk("drain_en", 32'(mul_enable), 0);
      chk("drain_wbv", 32'(wb_valid), 0);
    end
    @(negedge clock);
    mul_ready = 1'b1; mul_result = 32'd12;
    #1;
    chk("drain_ready_stall", 32'(stall), 1);
    chk("drain_ready_en", 32'(mul_enable), 0);
    @(negedge clock);
    mul_ready = 1'b0;
    #1;
    chk("drain_no_wb", 32'(wb_valid), 0);
    chk("post_drain_en", 32'(mul_enable), 1);
    chk("post_drain_stall", 32'(stall), 1);
    @(negedge clock);
    mul_ready = 1'b1; mul_result = 32'd30;
    #1;
    chk("post_drain_rdy_stall", 32'(stall), 0);
    @(negedge clock);
    ex_valid = 1'b0; mul_ready = 1'b0;
    #1;
    chk("post_drain_wbv", 32'(wb_valid), 1);
    chk("post_drain_wbr", wb_result, 32'd30);
    chk("post_drain_wba", 32'(wb_waddr), 7);
    run_op("refl", MULS, 32'd3, 32'd4, 5'd8, 32'd12, 32'd12, 0, 1'b0);

    // flush together with ready: discarded, cache keeps MULS 3*4
    @(negedge clock);
    req(MULH, 32'd1, 32'd1, 5'd3);
    #1;
    chk("flr_en", 32'(mul_enable), 1);
    @(negedge clock);
    flush = 1'b1; ex_valid = 1'b0; mul_ready = 1'b1; mul_result = 32'h0;
    #1;
    chk("flr_stall", 32'(stall), 0);
    @(negedge clock);
    flush = 1'b0; mul_ready = 1'b0;
    #1;
    chk("flr_no_wb", 32'(wb_valid), 0);
    run_op("hit34", MULS, 32'd3, 32'd4, 5'd2, 32'h00000BAD, 32'd12, 0, 1'b1);

    // malformed ops and a flushed request are ignored
    en_base = en_cnt;
    @(negedge clock);
    req(4'b0000, 32'd2, 32'd2, 5'd1);
    #1;
    chk("op0_en", 32'(mul_enable), 0);
    chk("op0_stall", 32'(stall), 0);
    @(negedge clock);
    ex_op = 4'b0011;
    #1;
    chk("op3_en", 32'(mul_enable), 0);
    chk("op3_stall", 32'(stall), 0);
    chk("op0_no_wb", 32'(wb_valid), 0);
    @(negedge clock);
    ex_op = MULS; flush = 1'b1;
    #1;
    chk("flreq_en", 32'(mul_enable), 0);
    chk("flreq_stall", 32'(stall), 0);
    chk("op3_no_wb", 32'(wb_valid), 0);
    @(negedge clock);
    ex_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flreq_no_wb", 32'(wb_valid), 0);
    chk("illegal_no_pulse", 32'(en_cnt - en_base), 0);

    // reset while busy drops the operation
    @(negedge clock);
    req(MULHU, 32'd2, 32'd3, 5'd4);
    #1;
    chk("rb_en", 32'(mul_enable), 1);
    @(negedge clock);
    #1;
    chk("rb_busy_stall", 32'(stall), 1);
    @(negedge clock);
    reset = 1'b0; ex_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("rb_stall", 32'(stall), 0);
    chk("rb_en0", 32'(mul_enable), 0);
    chk("rb_wbv", 32'(wb_valid), 0);
    chk("rb_wbr", wb_result, 0);
    chk("rb_wba", 32'(wb_waddr), 0);
    reset = 1'b1; mul_ready = 1'b1; mul_result = 32'd6;
    @(negedge clock);
    mul_ready = 1'b0;
    #1;
    chk("rb_no_wb", 32'(wb_valid), 0);
    run_op("rb_cache_cold", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Execute-stage sequencer directly upstream of the M-extension multiplier.
- Accepts multiply requests from the execute stage and launches each one into the multiplier with a single-cycle enable pulse.
- Stalls the pipeline until the multiplier reports ready, then registers the result for writeback.
- Supports combinational and iterative multipliers, flush/drain, and a one-entry result cache that bypasses the multiplier on an exact repeat.

Parameters:
- CACHE_EN, 1, 1 enables the one-entry result cache; 0 means every request goes to the multiplier.

Ports:
- clock      input   1   system clock
- reset      input   1   synchronous, active-low reset
- ex_valid   input   1   multiply request present this cycle
- ex_op      input   4   one-hot {mulhu, mulhsu, mulh, muls}
- ex_rdata1  input   32  operand 1
- ex_rdata2  input   32  operand 2
- ex_waddr   input   5   destination register
- flush      input   1   kill the current/in-flight request
- stall      output  1   hold the execute stage (combinational)
- mul_enable output  1   launch pulse to the multiplier
- mul_op     output  4   op to the multiplier
- mul_rdata1 output  32  operand 1 to the multiplier
- mul_rdata2 output  32  operand 2 to the multiplier
- mul_result input   32  multiplier result, valid when mul_ready=1
- mul_ready  input   1   multiplier completion; may be high in the launch cycle (combinational multiplier) or up to 34 cycles later
- wb_valid   output  1   one-cycle writeback pulse
- wb_waddr   output  5   writeback destination
- wb_result  output  32  writeback data

Behaviour:
- Reset is synchronous, active-low, on clock. Reset state:
  - state=IDLE; wb_valid=0, wb_waddr=0, wb_result=0.
  - Cache invalid; held op/operand/waddr registers cleared.
  - Reset mid-operation drops everything: no wb. The multiplier shares the same reset.
- States: IDLE, BUSY, DRAIN.
- A request is "legal" when ex_valid=1, ex_op is exactly one-hot, and flush=0.
  - Illegal or flushed requests are ignored: no launch, no stall, no wb.
- Cache hit: CACHE_EN=1, cache valid, and ex_op, ex_rdata1, ex_rdata2 all equal the cached values.
- IDLE, legal request with cache hit:
  - mul_enable=0, stall=0.
  - Next cycle: wb_valid=1, wb_result=cached result, wb_waddr=ex_waddr.
- IDLE, legal request without hit (launch cycle):
  - mul_enable=1; mul_op/mul_rdata* driven straight from the ex_* inputs.
  - Latch op, operands, and waddr into held registers.
  - If mul_ready=1 in the same cycle: stall=0, capture mul_result, wb next cycle, update cache, stay IDLE.
  - Otherwise: stall=1, go to BUSY.
- BUSY:
  - mul_enable=0; mul_op/mul_rdata* driven from the held registers, stable.
  - stall = !mul_ready.
  - On mul_ready=1 with flush=0: capture result, wb next cycle with the held waddr, update cache, go IDLE.
  - On flush=1 and mul_ready=0: go DRAIN, no wb.
  - On flush=1 and mul_ready=1 in the same cycle: discard, go IDLE, cache not updated.
- DRAIN:
  - stall=1, mul_enable=0.
  - Wait for mul_ready, then discard the result and go IDLE. flush is ignored.
  - The multiplier cannot be aborted, so a new launch is never issued until it returns.
- A new request is only sampled in IDLE. The execute stage holds ex_* stable while stall=1.
- wb_valid is a single-cycle pulse. wb_result/wb_waddr hold their last value while wb_valid=0.
- Back-to-back: after a completion to IDLE, a new launch may occur in the very next cycle.
  - With a combinational multiplier, sustained throughput is 1 op/cycle with wb lagging by 1 cycle.
- mul_enable is never asserted outside IDLE.
- Cache update rule: store op, rdata1, rdata2, and result on every non-flushed completion.
  - A hit returns the result only; the cache holds no waddr.
  - Never invalidated except by reset (pure function of its inputs).

Test Plan:
- Combinational multiplier: MUL 7 × 0xFFFFFFFD -> stall never asserted; wb_valid cycle+1, wb_result=0xFFFFFFEB.
- Iterative multiplier: MULHU 0xFFFFFFFF × 0xFFFFFFFF -> stall high until mul_ready; exactly one mul_enable pulse; wb_result=0xFFFFFFFE one cycle after ready.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF (both latency variants).
- Repeat the identical MULHU request with CACHE_EN=1 -> mul_enable stays 0; wb next cycle with 0xFFFFFFFE. With CACHE_EN=0 -> full relaunch.
- Iterative multiplier, flush 3 cycles after launch -> DRAIN; stall held until mul_ready; no wb_valid; a following request launches only after drain; cache unchanged.
- ex_valid with ex_op=0000 or 0011 -> no launch, no stall, no wb. Reset asserted while BUSY -> IDLE, all outputs 0, no wb after reset release.
